// File: rtl/hdmi_video_core.sv
// Raster timing generator and flat-colour pixel source for the HDMI/DVI path.
// One pixel per clock. Active area is programmable; blanking is parameterised.
module hdmi_video_core #(
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] hres,
  input  logic [9:0]  vres,
  input  logic [23:0] color,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        ve
);

  localparam int unsigned HW = 12;
  localparam int unsigned VW = 11;

  logic          r_running;
  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [10:0]   r_hres_s;
  logic [9:0]    r_vres_s;
  logic [23:0]   r_rgb;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_ve;

  logic [HW-1:0] w_hres_x;
  logic [VW-1:0] w_vres_x;
  logic [HW-1:0] w_htot;
  logic [VW-1:0] w_vtot;
  logic [HW-1:0] w_hs_beg;
  logic [HW-1:0] w_hs_end;
  logic [VW-1:0] w_vs_beg;
  logic [VW-1:0] w_vs_end;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_act;
  logic          w_hs;
  logic          w_vs;

  // Line/frame geometry and region decode from the shadowed active size
  always_comb begin
    w_hres_x = HW'(r_hres_s);
    w_vres_x = VW'(r_vres_s);
    w_htot   = w_hres_x + HW'(H_FP + H_SYNC + H_BP);
    w_vtot   = w_vres_x + VW'(V_FP + V_SYNC + V_BP);
    w_hs_beg = w_hres_x + HW'(H_FP);
    w_hs_end = w_hs_beg + HW'(H_SYNC);
    w_vs_beg = w_vres_x + VW'(V_FP);
    w_vs_end = w_vs_beg + VW'(V_SYNC);
    w_h_last = (r_hcnt == w_htot - HW'(1));
    w_v_last = (r_vcnt == w_vtot - VW'(1));
    w_act    = (r_hcnt < w_hres_x) && (r_vcnt < w_vres_x);
    w_hs     = (r_hcnt >= w_hs_beg) && (r_hcnt < w_hs_end);
    w_vs     = (r_vcnt >= w_vs_beg) && (r_vcnt < w_vs_end);
  end

  // Run flag, pixel/line counters and active-size shadow registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_running <= 1'b0;
      r_hcnt    <= '0;
      r_vcnt    <= '0;
      r_hres_s  <= '0;
      r_vres_s  <= '0;
    end else if (!r_running) begin
      if (start) begin
        r_running <= 1'b1;
        r_hres_s  <= hres;
        r_vres_s  <= vres;
      end
    end else if (w_h_last) begin
      r_hcnt <= '0;
      if (w_v_last) begin
        // Frame wrap: pick up any new active size for the coming frame
        r_vcnt   <= '0;
        r_hres_s <= hres;
        r_vres_s <= vres;
      end else begin
        r_vcnt <= r_vcnt + VW'(1);
      end
    end else begin
      r_hcnt <= r_hcnt + HW'(1);
    end
  end

  // Registered pixel and sync outputs, one clock behind the counters
  always_ff @(posedge clock) begin
    if (reset || !r_running) begin
      r_ve    <= 1'b0;
      r_rgb   <= '0;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
    end else begin
      r_ve    <= w_act;
      r_rgb   <= w_act ? color : 24'h000000;
      r_hsync <= w_hs ? SYNC_POL : ~SYNC_POL;
      r_vsync <= w_vs ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign red   = r_rgb[23:16];
  assign green = r_rgb[15:8];
  assign blue  = r_rgb[7:0];
  assign hsync = r_hsync;
  assign vsync = r_vsync;
  assign ve    = r_ve;

endmodule

// File: tb/tb_hdmi_video_core.sv
// Bench for hdmi_video_core: timing-point vector table, hand-written corner
// sequences, and a randomized run against a frame-position reference model.
module tb_hdmi_video_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [10:0] hres = 11'd800;
  logic [9:0]  vres = 10'd600;
  logic [23:0] color = 24'h112233;
  logic [7:0]  red, green, blue;
  logic        hsync, vsync, ve;

  int n_checks = 0;
  int n_errors = 0;

  hdmi_video_core dut (
    .clock(clk), .reset(reset), .start(start), .hres(hres), .vres(vres),
    .color(color), .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .ve(ve)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_ve, input logic [23:0] e_rgb,
                         input logic e_hs, input logic e_vs);
    chk({tag, ".ve"},    32'(ve), 32'(e_ve));
    chk({tag, ".rgb"},   32'({red, green, blue}), 32'(e_rgb));
    chk({tag, ".hsync"}, 32'(hsync), 32'(e_hs));
    chk({tag, ".vsync"}, 32'(vsync), 32'(e_vs));
  endtask

  // Reset for one edge, then one start edge (T); afterwards k edges past T
  task automatic restart(input logic [10:0] h, input logic [9:0] v, input logic [23:0] c);
    hres = h; vres = v; color = c;
    reset = 1'b1; start = 1'b0; step();
    reset = 1'b0; start = 1'b1; step();
    start = 1'b0;
  endtask

  typedef struct {
    logic [10:0] h;
    logic [9:0]  v;
    int          k;
    logic        e_ve;
    logic        e_hs;
    logic        e_vs;
  } vec_t;

  vec_t vt[14];

  // Reference model: position within the frame from a linear pixel index
  bit      m_run;
  int      m_p, m_h, m_v;
  logic    e_ve, e_hs, e_vs;
  logic [23:0] e_rgb;

  task automatic model_edge(input logic rst, input logic st, input logic [10:0] h,
                            input logic [9:0] v, input logic [23:0] c);
    int htot, vtot, x, y;
    if (rst) begin
      m_run = 0; m_p = 0;
      e_ve = 0; e_rgb = 0; e_hs = 0; e_vs = 0;
    end else if (!m_run) begin
      e_ve = 0; e_rgb = 0; e_hs = 0; e_vs = 0;
      if (st) begin
        m_run = 1; m_p = 0; m_h = int'(h); m_v = int'(v);
      end
    end else begin
      htot = m_h + 40 + 128 + 88;
      vtot = m_v + 1 + 4 + 23;
      x = m_p % htot;
      y = m_p / htot;
      e_ve  = (x < m_h) && (y < m_v);
      e_rgb = e_ve ? c : 24'h0;
      e_hs  = (x >= m_h + 40) && (x < m_h + 168);
      e_vs  = (y >= m_v + 1) && (y < m_v + 5);
      m_p++;
      if (m_p == htot * vtot) begin
        m_p = 0; m_h = int'(h); m_v = int'(v);
      end
    end
  endtask

  initial begin
    // 800x600: htot 1056. Output after edge T+k shows pixel k-1.
    vt[0]  = '{11'd800, 10'd600, 1,    1'b1, 1'b0, 1'b0};
    vt[1]  = '{11'd800, 10'd600, 800,  1'b1, 1'b0, 1'b0};
    vt[2]  = '{11'd800, 10'd600, 801,  1'b0, 1'b0, 1'b0};
    vt[3]  = '{11'd800, 10'd600, 840,  1'b0, 1'b0, 1'b0};
    vt[4]  = '{11'd800, 10'd600, 841,  1'b0, 1'b1, 1'b0};
    vt[5]  = '{11'd800, 10'd600, 968,  1'b0, 1'b1, 1'b0};
    vt[6]  = '{11'd800, 10'd600, 969,  1'b0, 1'b0, 1'b0};
    vt[7]  = '{11'd800, 10'd600, 1057, 1'b1, 1'b0, 1'b0};
    // 8x3: htot 264, vtot 31, vsync on lines 4..7, frame 8184 clocks
    vt[8]  = '{11'd8, 10'd3, 1056, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{11'd8, 10'd3, 1057, 1'b0, 1'b0, 1'b1};
    vt[10] = '{11'd8, 10'd3, 2112, 1'b0, 1'b0, 1'b1};
    vt[11] = '{11'd8, 10'd3, 2113, 1'b0, 1'b0, 1'b0};
    vt[12] = '{11'd8, 10'd3, 8184, 1'b0, 1'b0, 1'b0};
    vt[13] = '{11'd8, 10'd3, 8185, 1'b1, 1'b0, 1'b0};

    // Reset held 3 clocks with start low, then idle while start stays low
    reset = 1'b1; start = 1'b0;
    repeat (3) step();
    chk_all("reset", 1'b0, 24'h0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (5) step();
    chk_all("idle", 1'b0, 24'h0, 1'b0, 1'b0);

    // Reset wins over start on the same edge
    reset = 1'b1; start = 1'b1; step();
    reset = 1'b0; start = 1'b0;
    repeat (3) step();
    chk_all("rst_over_start", 1'b0, 24'h0, 1'b0, 1'b0);

    // Table of timing points
    for (int i = 0; i < 14; i++) begin
      restart(vt[i].h, vt[i].v, 24'h112233);
      repeat (vt[i].k) step();
      chk_all($sformatf("vec%0d", i), vt[i].e_ve,
              vt[i].e_ve ? 24'h112233 : 24'h0, vt[i].e_hs, vt[i].e_vs);
    end

    // Colour change mid-line, blanking stays black, then reset mid-line
    restart(11'd800, 10'd600, 24'h112233);
    repeat (10) step();
    chk("col_before", 32'({red, green, blue}), 32'h112233);
    color = 24'hFFFFFF; step();
    chk("col_after", 32'({red, green, blue}), 32'hFFFFFF);
    repeat (794) step();                       // k = 805, pixel 804
    chk("col_blank", 32'({red, green, blue}), 32'h0);
    chk("ve_blank", 32'(ve), 32'h0);
    repeat (95) step();                        // k = 900, inside hsync
    chk("hs_mid", 32'(hsync), 32'h1);
    reset = 1'b1; step();
    chk_all("rst_mid", 1'b0, 24'h0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (20) step();
    chk_all("rst_idle", 1'b0, 24'h0, 1'b0, 1'b0);

    // hres change mid-frame applies only from the next frame
    restart(11'd8, 10'd3, 24'h112233);
    hres = 11'd16;
    repeat (275) step();                       // frame0 line1 x10, old width 8
    chk("hres_old", 32'(ve), 32'h0);
    repeat (8195 - 275) step();                // frame1 line0 x10, width 16
    chk("hres_new", 32'(ve), 32'h1);
    repeat (8449 - 8195) step();               // frame1 x264, htot now 272
    chk("htot_new", 32'(ve), 32'h0);

    // Randomized run against the reference model
    hres = 11'd8; vres = 10'd2;
    for (int i = 0; i < 20000; i++) begin
      reset = (i == 0) || ($urandom_range(0, 3999) == 0);
      start = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 199) == 0) begin
        hres = 11'($urandom_range(1, 16));
        vres = 10'($urandom_range(1, 4));
      end
      color = 24'($urandom);
      step();
      model_edge(reset, start, hres, vres, color);
      chk_all("rand", e_ve, e_rgb, e_hs, e_vs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
